// File: rtl/hdc_pkg.sv
// Shared constants and types for the hyperdimensional bundling datapath.
package hdc_pkg;

   localparam int DIM_DEFAULT    = 10000;
   localparam int NUM_IN_DEFAULT = 16;

   typedef enum logic {
      ACCUM = 1'b0,
      EMIT  = 1'b1
   } bundlerState_t;

endpackage

// File: rtl/hv_dim_slice.sv
// One hypervector dimension: running ones-count plus the majority/tie decision
// that is registered on the bundle's final beat.
module hv_dim_slice #(
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             accept,
   input  logic             last,
   input  logic             inBit,
   input  logic             tieBit,
   input  logic [CNT_W-1:0] beatTotal,
   output logic             outBit
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W:0]   ones;
   logic [CNT_W+1:0] twiceOnes;
   logic [CNT_W+1:0] total;
   logic             majority;

   // Compare twice the ones-count against the beat total so ties stay exact.
   always_comb begin
      ones      = {1'b0, cnt} + {{CNT_W{1'b0}}, inBit};
      twiceOnes = {ones, 1'b0};
      total     = {2'b00, beatTotal};
      if (twiceOnes > total) begin
         majority = 1'b1;
      end else if (twiceOnes < total) begin
         majority = 1'b0;
      end else begin
         majority = tieBit;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         outBit <= 1'b0;
      end else if (accept) begin
         if (last) begin
            cnt    <= '0;
            outBit <= majority;
         end else begin
            cnt <= ones[CNT_W-1:0];
         end
      end
   end

endmodule

// File: rtl/hv_bundler.sv
// Bitwise-majority bundler: accumulates up to NUM_IN hypervectors per bundle
// and presents the majority vector with its beat count on a valid/ready output.
module hv_bundler
   import hdc_pkg::*;
#(
   parameter  int DIM    = DIM_DEFAULT,
   parameter  int NUM_IN = NUM_IN_DEFAULT,
   localparam int CNT_W  = $clog2(NUM_IN + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DIM-1:0]   in_hv,
   input  logic             in_last,
   input  logic [DIM-1:0]   tie_hv,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DIM-1:0]   out_hv,
   output logic [CNT_W-1:0] out_count
);

   bundlerState_t    state;
   bundlerState_t    nextState;
   logic [CNT_W-1:0] n;
   logic [CNT_W-1:0] beatTotal;
   logic             accept;
   logic             lastBeat;

   assign in_ready  = (state == ACCUM);
   assign out_valid = (state == EMIT);
   assign accept    = in_valid & in_ready;
   // The NUM_IN-th beat closes the bundle even without in_last.
   assign lastBeat  = in_last | (n == CNT_W'(NUM_IN - 1));
   assign beatTotal = n + CNT_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ACCUM;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         ACCUM: begin
            if (accept && lastBeat) begin
               nextState = EMIT;
            end
         end
         EMIT: begin
            if (out_ready) begin
               nextState = ACCUM;
            end
         end
         default: nextState = ACCUM;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n         <= '0;
         out_count <= '0;
      end else if (accept) begin
         if (lastBeat) begin
            n         <= '0;
            out_count <= beatTotal;
         end else begin
            n <= beatTotal;
         end
      end
   end

   for (genvar i = 0; i < DIM; i++) begin : g_slice
      hv_dim_slice #(
         .CNT_W(CNT_W)
      ) u_slice (
         .clk      (clk),
         .rst      (rst),
         .accept   (accept),
         .last     (lastBeat),
         .inBit    (in_hv[i]),
         .tieBit   (tie_hv[i]),
         .beatTotal(beatTotal),
         .outBit   (out_hv[i])
      );
   end

endmodule

// File: doc/hv_bundler.md
HV_BUNDLER -- requirements
Module: hv_bundler

Interface
REQ-001 SHALL have parameter DIM, default 10000, hypervector width in bits.
REQ-002 SHALL have parameter NUM_IN, default 16, maximum number of hypervectors bundled per output.
REQ-003 SHALL have derived localparam CNT_W = $clog2(NUM_IN+1), width of all counts.
REQ-004 SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  in_hv, in_last and tie_hv carry a beat.
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 in_hv  input  DIM  binary hypervector to bundle, typically the LFSR item-memory output.
REQ-010 in_last  input  1  final beat of the current bundle.
REQ-011 tie_hv  input  DIM  tie-break hypervector, typically a second LFSR output.
REQ-012 out_valid  output  1  out_hv and out_count hold a result.
REQ-013 out_ready  input  1  consumer takes the result.
REQ-014 out_hv  output  DIM  bitwise majority of the bundle.
REQ-015 out_count  output  CNT_W  number of beats in the bundle.

Function
REQ-016 SHALL implement two states: ACCUM (in_ready=1, out_valid=0) and EMIT (in_ready=0, out_valid=1).
REQ-017 In ACCUM, each accepted beat (in_valid & in_ready) SHALL add in_hv[i] to per-dimension counter cnt[i] and increment beat counter n.
REQ-018 A beat SHALL be treated as last when in_last=1 or when it is the NUM_IN-th beat; no counter SHALL ever exceed NUM_IN.
REQ-019 On the last-beat clock edge, the block SHALL register out_hv[i]=1 if 2*(cnt[i]+in_hv[i]) > n+1, =0 if less, and =tie_hv[i] if equal.
REQ-020 On the same edge it SHALL set out_count=n+1, clear cnt[] and n, and enter EMIT.
REQ-021 out_valid SHALL therefore rise exactly one cycle after the last accepted beat.
REQ-022 In EMIT, out_hv and out_count SHALL stay stable until out_valid & out_ready.
REQ-023 On that handshake the block SHALL return to ACCUM, with in_ready=1 in the next cycle.
REQ-024 No beat SHALL be accepted in the same cycle as the output handshake.
REQ-025 in_ready SHALL be a pure function of state, independent of in_valid and out_ready.
REQ-026 tie_hv SHALL be sampled only on the last-beat edge and ignored otherwise.
REQ-027 A single-beat bundle (in_last on the first beat) SHALL yield out_hv=in_hv and out_count=1.

Reset
REQ-028 rst SHALL asynchronously force state=ACCUM, cnt[]=0, n=0, out_valid=0, out_hv=0, out_count=0.
REQ-029 Reset mid-bundle or during EMIT SHALL discard all partial or pending results; the first bundle after reset SHALL be independent of prior beats.
REQ-030 in_ready SHALL be 1 during and after reset.

Structure
REQ-031 Package hdc_pkg SHALL hold the default DIM and NUM_IN constants and the bundler state enum (ACCUM, EMIT).
REQ-032 Sub-module hv_dim_slice SHALL hold one dimension's counter and majority/tie compare.
REQ-033 hv_dim_slice SHALL be instantiated DIM times via generate.
REQ-034 The state machine and beat counter SHALL live in hv_bundler.

Verification (DIM=8, NUM_IN=4, out_ready=1 unless stated)
REQ-035 Beats 8'hF0, 8'hCC, 8'hAA (last on third) -> out_hv=8'hE8 and out_count=3, one cycle after the third beat.
REQ-036 Beats 8'hFF, 8'h00 (last), tie_hv=8'h5A on the last beat -> out_hv=8'h5A, out_count=2.
REQ-037 Beats 8'h0F, 8'h0F, 8'hF0, 8'h01 with in_last=0 throughout and tie_hv=8'h00 -> forced end, out_hv=8'h01, out_count=4; repeated with tie_hv=8'hFF -> out_hv=8'h0F.
REQ-038 Backpressure: out_ready=0 for 5 cycles after out_valid -> out_hv and out_count stable, in_ready=0, no held in_valid beat accepted; out_ready=1 -> handshake, then in_ready=1 next cycle.
REQ-039 Two beats accepted, then rst pulsed -> out_valid=0 immediately; then single beat 8'h3C with last -> out_hv=8'h3C, out_count=1.
REQ-040 Random stress: 1000 bundles with random lengths 1..4, random valid/ready gaps, DIM=8 -> every result matches the software majority/tie model.
